front_sched: RTL and testbench

- Front-end pipeline scheduler for the amber core.
- Generates the stall, flush and PC-redirect controls that drive the address, fetch, translate and decode stages (IA/IF/XT/ID).
- Arbitrates between the hazard sources: translate-stage micro-op expansion, load-use, memory wait, taken branches and halt/wake.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/front_sched_pkg.sv | 22 ++
 rtl/front_sched_sat_counter.sv | 33 +++
 rtl/front_sched.sv | 202 ++++++++++++++++++++
 tb/tb_front_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/front_sched_pkg.sv
// Shared types and constants for the amber front-end scheduler.
package front_sched_pkg;

   localparam int SIZE_ADDR     = 16;
   localparam int HBIT_ADDR     = SIZE_ADDR - 1;
   localparam int FLUSH_CYC_DEF = 1;
   localparam int DRAIN_CYC_DEF = 4;
   localparam int SEQ_W         = 3;

   typedef enum logic [1:0] {
      FS_RUN   = 2'd0,
      FS_FLUSH = 2'd1,
      FS_DRAIN = 2'd2,
      FS_HALT  = 2'd3
   } fs_state_e;

   // Sequencing counters are loaded with n-1 so a state lasts exactly n counted cycles.
   function automatic logic [SEQ_W-1:0] seq_load(input int n);
      return SEQ_W'(n - 1);
   endfunction

endpackage

// File: rtl/front_sched_sat_counter.sv
// Parameterised saturating up-counter with enable; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         iw_clk,
   input  logic         iw_rst_n,
   input  logic         iw_en,
   output logic [W-1:0] ow_cnt
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (iw_en && !(&cnt_q)) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ow_cnt = cnt_q;

endmodule

// File: rtl/front_sched.sv
// Front-end stall/flush/redirect scheduler for IA/IF/XT/ID with halt/wake sequencing
// and a saturating stall-cycle counter.
module front_sched
   import front_sched_pkg::*;
#(
   parameter int FLUSH_CYC = FLUSH_CYC_DEF,
   parameter int DRAIN_CYC = DRAIN_CYC_DEF,
   parameter int CNT_W     = 16
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst_n,
   input  logic                 iw_xt_busy,
   input  logic                 iw_ld_use,
   input  logic                 iw_mem_wait,
   input  logic                 iw_br_taken,
   input  logic [HBIT_ADDR:0]   iw_br_pc,
   input  logic                 iw_halt,
   input  logic [HBIT_ADDR:0]   iw_halt_pc,
   input  logic                 iw_wake,
   output logic                 ow_stall_fe,
   output logic                 ow_stall_xd,
   output logic                 ow_stall_be,
   output logic                 ow_bubble_ex,
   output logic                 ow_flush_fe,
   output logic                 ow_redir_v,
   output logic [HBIT_ADDR:0]   ow_redir_pc,
   output logic                 ow_halted,
   output logic [CNT_W-1:0]     ow_stall_cnt
);

   fs_state_e            st_d, st_q;
   logic [SEQ_W-1:0]     seq_d, seq_q;
   logic                 pend_v_d, pend_v_q;
   logic [HBIT_ADDR:0]   pend_pc_d, pend_pc_q;
   logic [HBIT_ADDR:0]   halt_pc_d, halt_pc_q;
   logic                 redir_v_d, redir_v_q;
   logic [HBIT_ADDR:0]   redir_pc_d, redir_pc_q;
   logic                 flush_d, flush_q;
   logic                 halted_d, halted_q;
   logic                 take_s;
   logic [HBIT_ADDR:0]   take_pc_s;
   logic                 br_ok_s;

   // Redirect selection: a branch during memory wait parks in the pending slot (youngest wins).
   always_comb begin
      br_ok_s   = iw_br_taken && (st_q != FS_HALT);
      take_s    = 1'b0;
      take_pc_s = iw_br_pc;
      pend_v_d  = pend_v_q;
      pend_pc_d = pend_pc_q;
      if (iw_mem_wait) begin
         if (br_ok_s) begin
            pend_v_d  = 1'b1;
            pend_pc_d = iw_br_pc;
         end else begin
            pend_v_d  = pend_v_q;
         end
      end else if (br_ok_s) begin
         take_s    = 1'b1;
         take_pc_s = iw_br_pc;
         pend_v_d  = 1'b0;
      end else if (pend_v_q) begin
         take_s    = 1'b1;
         take_pc_s = pend_pc_q;
         pend_v_d  = 1'b0;
      end else begin
         take_s    = 1'b0;
      end
   end

   // FSM next state and registered redirect/flush/halt outputs.
   always_comb begin
      st_d       = st_q;
      seq_d      = seq_q;
      halt_pc_d  = halt_pc_q;
      redir_v_d  = 1'b0;
      redir_pc_d = redir_pc_q;
      case (st_q)
         FS_RUN, FS_FLUSH, FS_DRAIN: begin
            if (take_s) begin
               st_d       = FS_FLUSH;
               seq_d      = seq_load(FLUSH_CYC);
               redir_v_d  = 1'b1;
               redir_pc_d = take_pc_s;
            end else if (st_q == FS_RUN) begin
               // A HLT behind a pending redirect is on the wrong path and is dropped.
               if (iw_halt && !iw_br_taken && !pend_v_q) begin
                  st_d      = FS_DRAIN;
                  seq_d     = seq_load(DRAIN_CYC);
                  halt_pc_d = iw_halt_pc + SIZE_ADDR'(1);
               end else begin
                  st_d = FS_RUN;
               end
            end else if (st_q == FS_FLUSH) begin
               if (seq_q == '0) begin
                  st_d = FS_RUN;
               end else begin
                  seq_d = seq_q - SEQ_W'(1);
               end
            end else if (!iw_mem_wait) begin
               if (seq_q == '0) begin
                  st_d = FS_HALT;
               end else begin
                  seq_d = seq_q - SEQ_W'(1);
               end
            end else begin
               seq_d = seq_q;
            end
         end
         FS_HALT: begin
            if (iw_wake) begin
               st_d       = FS_FLUSH;
               seq_d      = seq_load(FLUSH_CYC);
               redir_v_d  = 1'b1;
               redir_pc_d = halt_pc_q;
            end else begin
               st_d = FS_HALT;
            end
         end
         default: begin
            st_d = FS_RUN;
         end
      endcase
      flush_d  = (st_d == FS_FLUSH);
      halted_d = (st_d == FS_HALT);
   end

   // Zero-latency stall and bubble generation in priority order.
   always_comb begin
      ow_stall_fe  = 1'b0;
      ow_stall_xd  = 1'b0;
      ow_stall_be  = 1'b0;
      ow_bubble_ex = 1'b0;
      if (iw_mem_wait) begin
         ow_stall_fe = 1'b1;
         ow_stall_xd = 1'b1;
         ow_stall_be = 1'b1;
      end else begin
         case (st_q)
            FS_FLUSH: begin
               ow_stall_fe = 1'b0;
            end
            FS_DRAIN, FS_HALT: begin
               ow_stall_fe = 1'b1;
               ow_stall_xd = 1'b1;
            end
            FS_RUN: begin
               if (iw_ld_use) begin
                  ow_stall_fe  = 1'b1;
                  ow_stall_xd  = 1'b1;
                  ow_bubble_ex = 1'b1;
               end else if (iw_xt_busy) begin
                  ow_stall_fe = 1'b1;
               end else begin
                  ow_stall_fe = 1'b0;
               end
            end
            default: begin
               ow_stall_fe = 1'b0;
            end
         endcase
      end
   end

   // State, sequencing counter, pending target and registered outputs.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         st_q       <= FS_RUN;
         seq_q      <= '0;
         pend_v_q   <= 1'b0;
         pend_pc_q  <= '0;
         halt_pc_q  <= '0;
         redir_v_q  <= 1'b0;
         redir_pc_q <= '0;
         flush_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         st_q       <= st_d;
         seq_q      <= seq_d;
         pend_v_q   <= pend_v_d;
         pend_pc_q  <= pend_pc_d;
         halt_pc_q  <= halt_pc_d;
         redir_v_q  <= redir_v_d;
         redir_pc_q <= redir_pc_d;
         flush_q    <= flush_d;
         halted_q   <= halted_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .iw_clk   (iw_clk),
      .iw_rst_n (iw_rst_n),
      .iw_en    (ow_stall_fe | ow_stall_xd | ow_stall_be),
      .ow_cnt   (ow_stall_cnt)
   );

   assign ow_flush_fe = flush_q;
   assign ow_redir_v  = redir_v_q;
   assign ow_redir_pc = redir_pc_q;
   assign ow_halted   = halted_q;

endmodule

// File: tb/tb_front_sched.sv
// Directed bench for front_sched: redirects are scoreboarded through a queue,
// stall/flush/halt expectations are given per step, and the stall counter is modelled.
module tb_front_sched;

   logic        iw_clk;
   logic        iw_rst_n;
   logic        iw_xt_busy;
   logic        iw_ld_use;
   logic        iw_mem_wait;
   logic        iw_br_taken;
   logic [15:0] iw_br_pc;
   logic        iw_halt;
   logic [15:0] iw_halt_pc;
   logic        iw_wake;
   logic        ow_stall_fe;
   logic        ow_stall_xd;
   logic        ow_stall_be;
   logic        ow_bubble_ex;
   logic        ow_flush_fe;
   logic        ow_redir_v;
   logic [15:0] ow_redir_pc;
   logic        ow_halted;
   logic [3:0]  ow_stall_cnt;

   typedef struct {
      int          cyc;
      logic [15:0] pc;
   } redir_t;

   redir_t     exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc_n = 0;
   logic [3:0] exp_cnt = 4'd0;

   // Expected stall vectors, ordered {fe, xd, be, bubble}.
   localparam logic [3:0] S_NONE = 4'b0000;
   localparam logic [3:0] S_MW   = 4'b1110;
   localparam logic [3:0] S_LD   = 4'b1101;
   localparam logic [3:0] S_XT   = 4'b1000;
   localparam logic [3:0] S_DR   = 4'b1100;

   front_sched #(.FLUSH_CYC(2), .DRAIN_CYC(4), .CNT_W(4)) dut (
      .iw_clk       (iw_clk),
      .iw_rst_n     (iw_rst_n),
      .iw_xt_busy   (iw_xt_busy),
      .iw_ld_use    (iw_ld_use),
      .iw_mem_wait  (iw_mem_wait),
      .iw_br_taken  (iw_br_taken),
      .iw_br_pc     (iw_br_pc),
      .iw_halt      (iw_halt),
      .iw_halt_pc   (iw_halt_pc),
      .iw_wake      (iw_wake),
      .ow_stall_fe  (ow_stall_fe),
      .ow_stall_xd  (ow_stall_xd),
      .ow_stall_be  (ow_stall_be),
      .ow_bubble_ex (ow_bubble_ex),
      .ow_flush_fe  (ow_flush_fe),
      .ow_redir_v   (ow_redir_v),
      .ow_redir_pc  (ow_redir_pc),
      .ow_halted    (ow_halted),
      .ow_stall_cnt (ow_stall_cnt)
   );

   initial iw_clk = 1'b0;
   always #5 iw_clk = ~iw_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic push_redir(input int cyc, input logic [15:0] pc);
      redir_t r;
      r.cyc = cyc;
      r.pc  = pc;
      exp_q.push_back(r);
   endtask

   task automatic chk_regs_clear();
      chk("rst_redir_v", 32'(ow_redir_v), 32'd0);
      chk("rst_redir_pc", 32'(ow_redir_pc), 32'd0);
      chk("rst_flush", 32'(ow_flush_fe), 32'd0);
      chk("rst_halted", 32'(ow_halted), 32'd0);
      chk("rst_cnt", 32'(ow_stall_cnt), 32'd0);
   endtask

   // One cycle: drive inputs just after the edge, check mid-cycle, then advance.
   task automatic step(input logic xt, input logic ld, input logic mw, input logic br,
                       input logic [15:0] brpc, input logic hl, input logic [15:0] hpc,
                       input logic wk, input logic [3:0] es, input logic ef, input logic eh);
      iw_xt_busy  = xt;
      iw_ld_use   = ld;
      iw_mem_wait = mw;
      iw_br_taken = br;
      iw_br_pc    = brpc;
      iw_halt     = hl;
      iw_halt_pc  = hpc;
      iw_wake     = wk;
      #3;
      chk("stall_fe", 32'(ow_stall_fe), 32'(es[3]));
      chk("stall_xd", 32'(ow_stall_xd), 32'(es[2]));
      chk("stall_be", 32'(ow_stall_be), 32'(es[1]));
      chk("bubble_ex", 32'(ow_bubble_ex), 32'(es[0]));
      chk("flush_fe", 32'(ow_flush_fe), 32'(ef));
      chk("halted", 32'(ow_halted), 32'(eh));
      chk("stall_cnt", 32'(ow_stall_cnt), 32'(exp_cnt));
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
         chk("redir_v", 32'(ow_redir_v), 32'd1);
         chk("redir_pc", 32'(ow_redir_pc), 32'(exp_q[0].pc));
         void'(exp_q.pop_front());
      end else begin
         chk("redir_v_idle", 32'(ow_redir_v), 32'd0);
      end
      @(posedge iw_clk);
      #1;
      if ((|es[3:1]) && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      cyc_n++;
   endtask

   task automatic idle(input logic [3:0] es, input logic ef, input logic eh);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, es, ef, eh);
   endtask

   initial begin
      iw_rst_n    = 1'b0;
      iw_xt_busy  = 1'b0;
      iw_ld_use   = 1'b0;
      iw_mem_wait = 1'b0;
      iw_br_taken = 1'b0;
      iw_br_pc    = 16'h0;
      iw_halt     = 1'b0;
      iw_halt_pc  = 16'h0;
      iw_wake     = 1'b0;
      #2;
      chk_regs_clear();
      repeat (2) @(posedge iw_clk);
      #3 iw_rst_n = 1'b1;
      @(posedge iw_clk);
      #1;

      // Idle after reset.
      repeat (5) idle(S_NONE, 1'b0, 1'b0);

      // Taken branch: redirect next cycle, flush held two cycles, load-use ignored while flushing.
      push_redir(cyc_n + 1, 16'h0123);
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0123, 1'b0, 16'h0, 1'b0, S_NONE, 1'b0, 1'b0);
      idle(S_NONE, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, S_NONE, 1'b1, 1'b0);
      idle(S_NONE, 1'b0, 1'b0);

      // Two branches under memory wait: youngest target issued after the wait drops.
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 16'h0, 1'b0, S_MW, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, S_MW, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0080, 1'b0, 16'h0, 1'b0, S_MW, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 16'h0, 1'b0, S_MW, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 16'h0, 1'b0, S_MW, 1'b0, 1'b0);
      push_redir(cyc_n + 1, 16'h0080);
      idle(S_NONE, 1'b0, 1'b0);
      idle(S_NONE, 1'b1, 1'b0);
      idle(S_NONE, 1'b1, 1'b0);
      idle(S_NONE, 1'b0, 1'b0);

      // Load-use dominates translate-busy; translate-busy alone stalls fetch only.
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, S_LD, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, S_XT, 1'b0, 1'b0);
      idle(S_NONE, 1'b0, 1'b0);

      // Halt: drain four unstalled cycles plus one wait cycle, then wake to PC+1.
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0200, 1'b0, S_NONE, 1'b0, 1'b0);
      idle(S_DR, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, S_MW, 1'b0, 1'b0);
      repeat (3) idle(S_DR, 1'b0, 1'b0);
      idle(S_DR, 1'b0, 1'b1);
      idle(S_DR, 1'b0, 1'b1);
      push_redir(cyc_n + 1, 16'h0201);
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, S_DR, 1'b0, 1'b1);
      idle(S_NONE, 1'b1, 1'b0);
      idle(S_NONE, 1'b1, 1'b0);
      idle(S_NONE, 1'b0, 1'b0);

      // Branch and HLT together: branch wins, no drain follows.
      push_redir(cyc_n + 1, 16'h0300);
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b1, 16'h0400, 1'b0, S_NONE, 1'b0, 1'b0);
      idle(S_NONE, 1'b1, 1'b0);
      idle(S_NONE, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, S_LD, 1'b0, 1'b0);
      idle(S_NONE, 1'b0, 1'b0);

      // Asynchronous reset mid-stall with a pending redirect outstanding.
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0500, 1'b0, 16'h0, 1'b0, S_MW, 1'b0, 1'b0);
      iw_br_taken = 1'b0;
      #2 iw_rst_n = 1'b0;
      #1;
      chk_regs_clear();
      iw_mem_wait = 1'b0;
      exp_cnt = 4'd0;
      repeat (2) @(posedge iw_clk);
      #3 iw_rst_n = 1'b1;
      @(posedge iw_clk);
      #1;
      cyc_n = cyc_n + 3;
      idle(S_NONE, 1'b0, 1'b0);
      idle(S_NONE, 1'b0, 1'b0);

      // Sustained stall: counter climbs to 15 and holds.
      repeat (20) step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, S_MW, 1'b0, 1'b0);
      idle(S_NONE, 1'b0, 1'b0);
      chk("sat_final", 32'(ow_stall_cnt), 32'd15);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
